hash_round_ctrl: RTL and testbench
==================================

HASH_ROUND_CTRL -- requirements
Module: hash_round_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- IV_A, 16'h6A09, initial a
- IV_B, 16'hBB67, initial b
- IV_C, 16'h3C6E, initial c
- IV_D, 16'hA54F, initial d
- K_TABLE, {16'h428A,16'h7137,16'hB5C0,16'hE9B5,16'h3956,16'h59F1,16'h923F,16'hAB1C}, round constants; K0 in the MSBs.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  sole clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  message offered
- in_ready  output  1  controller can accept a message
- in0..in5  input  8 each  message bytes
- out_valid  output  1  digest available
- out_ready  input  1  consumer accepts digest
- digest  output  64  {a,b,c,d} result
- busy  output  1  high in any state other than IDLE
- round_idx  output  3  current round number, 0 outside ROUND.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, ROUND, DONE.
REQ-004 IDLE: in_ready=1; on in_valid&in_ready, capture M0={in0,in1}, M1={in2,in3}, M2={in4,in5}, M3={13'b0,cnt} (cnt = number of non-zero input bytes, 0..6), then go to LOAD.
REQ-005 LOAD (1 cycle): register W0..W3=M0..M3; W4=ss(W1)+W3, W5=ss(W2)+W4, W6=ss(W3)+W5, W7=ss(W4)+W6; ss(x)=rotl(x,2)^rotl(x,7)^(x>>3); load a,b,c,d with IV_A..IV_D; go to ROUND with round_idx=0.
REQ-006 ROUND: one round per cycle, r=round_idx, using K_r and W_r.
- S1=rotl(c,2)+rotl(c,7)
- Ch=(b&c)|(~b&d)
- T1=S1^Ch^(d&K_r)^W_r
- S0=rotl(a,5)+rotl(a,11)
- Maj=(a&b)|(b&c)|(c&a)
- T2=Maj|S0
- update: a'=T1+T2, b'=a', c'=a'+T1, d'=c'.
REQ-007 All additions SHALL be modulo 2^16; carries are discarded.
REQ-008 round_idx SHALL increment each ROUND cycle; after round 7 the FSM SHALL go to DONE and round_idx SHALL return to 0; no wrap back into round 0.
REQ-009 DONE: out_valid=1 and digest={a,b,c,d}; digest SHALL be stable while out_valid=1 and out_ready=0.
REQ-010 DONE with out_ready=1 SHALL go to IDLE; in_ready rises the following cycle; no same-cycle accept bypass.
REQ-011 Latency: handshake in cycle N gives out_valid=1 in cycle N+10 (LOAD at N+1, rounds at N+2..N+9).
REQ-012 in_valid, input bytes and out_ready SHALL be ignored outside IDLE and DONE respectively; inputs are not re-sampled mid-operation.
REQ-013 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-014 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0, digest=0, and clear a..d, W0..W7 and M0..M3 to 0.
REQ-015 Reset asserted during LOAD, ROUND or DONE SHALL abort the operation with no digest produced; after release, the first edge sees IDLE.

Verification
REQ-016 Reset: hold rst_n=0 -> in_ready=1, out_valid=0, busy=0, round_idx=0, digest=64'h0; after release, in_ready=1 on the first edge.
REQ-017 Count field: in0=8'h01, others 0, single handshake -> captured M3=16'h0001; all six bytes 8'hFF -> M3=16'h0006; all zero -> M3=16'h0000.
REQ-018 Latency/round: accept at cycle N -> round_idx steps 0..7 over cycles N+2..N+9; out_valid=1 at N+10; digest matches a bit-accurate model of REQ-005..REQ-007.
REQ-019 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, digest constant; in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-020 Mid-op reset: assert rst_n=0 at round_idx=4 -> outputs per REQ-014 immediately; next message yields the same digest as one sent from a fresh reset.
REQ-021 Back-to-back: in_valid held high with two messages -> second accepted only after the first digest handshake; the two digests match the model independently.

Source files
------------

// File: rtl/hash_round_ctrl_if.sv
// Handshake and data bundle between hash_round_ctrl and its message producer / digest consumer.
// The master side drives messages and out_ready; the slave side (the controller) drives everything else.
interface hash_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [7:0]  in3;
    logic [7:0]  in4;
    logic [7:0]  in5;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] digest;
    logic        busy;
    logic [2:0]  round_idx;

    modport master (
        output in_valid, in0, in1, in2, in3, in4, in5, out_ready,
        input  in_ready, out_valid, digest, busy, round_idx
    );

    modport slave (
        input  in_valid, in0, in1, in2, in3, in4, in5, out_ready,
        output in_ready, out_valid, digest, busy, round_idx
    );
endinterface

// File: rtl/hash_round_ctrl.sv
// Eight-round, 16-bit-lane compression controller: accepts a 6-byte message, expands it to
// eight schedule words, runs one round per cycle and holds {a,b,c,d} until the consumer takes it.
module hash_round_ctrl #(
    parameter logic [15:0]  IV_A    = 16'h6A09,
    parameter logic [15:0]  IV_B    = 16'hBB67,
    parameter logic [15:0]  IV_C    = 16'h3C6E,
    parameter logic [15:0]  IV_D    = 16'hA54F,
    parameter logic [127:0] K_TABLE = {16'h428A, 16'h7137, 16'hB5C0, 16'hE9B5,
                                       16'h3956, 16'h59F1, 16'h923F, 16'hAB1C}
) (
    input  logic            clk,
    input  logic            rst_n,
    hash_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [2:0]  round_idx_q;

    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] m [4];
    logic [15:0] w [8];

    logic        accept;
    logic [2:0]  byte_cnt;
    logic [15:0] w4_next;
    logic [15:0] w5_next;
    logic [15:0] w6_next;
    logic [15:0] w7_next;

    logic [15:0] k_cur;
    logic [15:0] w_cur;
    logic [15:0] s1;
    logic [15:0] ch;
    logic [15:0] t1;
    logic [15:0] s0;
    logic [15:0] maj;
    logic [15:0] t2;
    logic [15:0] a_next;
    logic [15:0] c_next;

    function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] t;
        t = {x, x} << n;
        return t[31:16];
    endfunction

    function automatic logic [15:0] ss(input logic [15:0] x);
        return rotl(x, 4'd2) ^ rotl(x, 4'd7) ^ (x >> 3);
    endfunction

    // K0 lives in the top 16 bits, so round r reads the slice counted down from the MSB.
    function automatic logic [15:0] k_of(input logic [2:0] r);
        return K_TABLE[{3'd7 - r, 4'b0000} +: 16];
    endfunction

    function automatic logic [2:0] count_nonzero(input logic [47:0] bytes);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (bytes[8*i +: 8] != 8'h00) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    assign accept = (state == IDLE) && in_ready_q && bus.in_valid;

    always_comb begin
        byte_cnt = count_nonzero({bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5});
    end

    // Schedule expansion chains through the freshly computed words, all from the captured M registers.
    always_comb begin
        w4_next = ss(m[1]) + m[3];
        w5_next = ss(m[2]) + w4_next;
        w6_next = ss(m[3]) + w5_next;
        w7_next = ss(w4_next) + w6_next;
    end

    always_comb begin
        k_cur  = k_of(round_idx_q);
        w_cur  = w[round_idx_q];
        s1     = rotl(c, 4'd2) + rotl(c, 4'd7);
        ch     = (b & c) | (~b & d);
        t1     = s1 ^ ch ^ (d & k_cur) ^ w_cur;
        s0     = rotl(a, 4'd5) + rotl(a, 4'd11);
        maj    = (a & b) | (b & c) | (c & a);
        t2     = maj | s0;
        a_next = t1 + t2;
        c_next = a_next + t1;
    end

    // Control FSM; handshake flags are registered so in_ready and out_valid follow the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            round_idx_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= LOAD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    state       <= ROUND;
                    round_idx_q <= 3'd0;
                end
                ROUND: begin
                    if (round_idx_q == 3'd7) begin
                        state       <= DONE;
                        round_idx_q <= 3'd0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_idx_q <= round_idx_q + 3'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    round_idx_q <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= 16'h0000;
            b <= 16'h0000;
            c <= 16'h0000;
            d <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                m[i] <= 16'h0000;
            end
            for (int i = 0; i < 8; i++) begin
                w[i] <= 16'h0000;
            end
        end else begin
            if (accept) begin
                m[0] <= {bus.in0, bus.in1};
                m[1] <= {bus.in2, bus.in3};
                m[2] <= {bus.in4, bus.in5};
                m[3] <= {13'b0, byte_cnt};
            end
            if (state == LOAD) begin
                w[0] <= m[0];
                w[1] <= m[1];
                w[2] <= m[2];
                w[3] <= m[3];
                w[4] <= w4_next;
                w[5] <= w5_next;
                w[6] <= w6_next;
                w[7] <= w7_next;
                a    <= IV_A;
                b    <= IV_B;
                c    <= IV_C;
                d    <= IV_D;
            end
            // Working registers only move during ROUND, which keeps the digest frozen in DONE.
            if (state == ROUND) begin
                a <= a_next;
                b <= a_next;
                c <= c_next;
                d <= c_next;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.round_idx = round_idx_q;
    assign bus.digest    = {a, b, c, d};

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Self-checking bench for hash_round_ctrl: directed steps plus random messages, each digest
// compared against a plain-arithmetic reference of the schedule and round function.
module tb_hash_round_ctrl;

    logic clk;
    logic rst_n;
    int   compare_count;
    int   fail_count;

    hash_round_ctrl_if bus();

    hash_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [15:0] K_ROUND [8] = '{16'h428A, 16'h7137, 16'hB5C0, 16'hE9B5,
                                            16'h3956, 16'h59F1, 16'h923F, 16'hAB1C};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] rotl_model(input logic [15:0] x, input int n);
        return 16'((32'(x) << n) | (32'(x) >> (16 - n)));
    endfunction

    function automatic logic [15:0] sigma_model(input logic [15:0] x);
        return rotl_model(x, 2) ^ rotl_model(x, 7) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] model_digest(input logic [47:0] msg);
        logic [15:0] w [8];
        logic [15:0] a, b, c, d, t1, t2, na, nc;
        int cnt;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (msg[47 - 8*i -: 8] != 8'h00) cnt++;
        end
        w[0] = msg[47:32];
        w[1] = msg[31:16];
        w[2] = msg[15:0];
        w[3] = 16'(cnt);
        for (int i = 4; i < 8; i++) begin
            w[i] = sigma_model(w[i-3]) + w[i-1];
        end
        a = 16'h6A09; b = 16'hBB67; c = 16'h3C6E; d = 16'hA54F;
        for (int r = 0; r < 8; r++) begin
            t1 = (rotl_model(c, 2) + rotl_model(c, 7)) ^ ((b & c) | (~b & d))
                 ^ (d & K_ROUND[r]) ^ w[r];
            t2 = ((a & b) | (b & c) | (c & a)) | (rotl_model(a, 5) + rotl_model(a, 11));
            na = t1 + t2;
            nc = na + t1;
            a = na; b = na; c = nc; d = nc;
        end
        return {a, b, c, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [47:0] msg);
        bus.in_valid = valid;
        bus.in0 = msg[47:40];
        bus.in1 = msg[39:32];
        bus.in2 = msg[31:24];
        bus.in3 = msg[23:16];
        bus.in4 = msg[15:8];
        bus.in5 = msg[7:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_busy"},      64'(bus.busy),      64'd0);
        checkOutput({tag, "_round_idx"}, 64'(bus.round_idx), 64'd0);
        checkOutput({tag, "_digest"},    bus.digest,         64'd0);
    endtask

    function automatic logic [47:0] random_msg();
        logic [47:0] msg;
        for (int i = 0; i < 6; i++) begin
            msg[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        return msg;
    endfunction

    // Called at a falling edge; offers msg, then follows it through LOAD, ROUND, DONE and back to IDLE.
    task automatic run_message(input string tag, input logic [47:0] msg, input int stall,
                               input logic hold_valid, input logic [47:0] next_msg);
        logic [63:0] expected;
        int waited;
        expected = model_digest(msg);
        applyStimulus(1'b1, msg);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_accept_no_out_valid"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        if (hold_valid) applyStimulus(1'b1, next_msg);
        else applyStimulus(1'b0, random_msg());
        bus.out_ready = 1'b1;
        checkOutput({tag, "_load_busy"}, 64'(bus.busy), 64'd1);
        checkOutput({tag, "_load_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, "_load_round_idx"}, 64'(bus.round_idx), 64'd0);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            checkOutput({tag, "_round_idx"}, 64'(bus.round_idx), 64'(r));
            checkOutput({tag, "_round_out_valid"}, 64'(bus.out_valid), 64'd0);
            checkOutput({tag, "_round_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_done_out_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({tag, "_done_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({tag, "_done_busy"}, 64'(bus.busy), 64'd1);
        checkOutput({tag, "_done_round_idx"}, 64'(bus.round_idx), 64'd0);
        checkOutput({tag, "_digest"}, bus.digest, expected);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput({tag, "_stall_out_valid"}, 64'(bus.out_valid), 64'd1);
            checkOutput({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
            checkOutput({tag, "_stall_digest"}, bus.digest, expected);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [47:0] abort_msg;
        logic [47:0] msg_a;
        logic [47:0] msg_b;
        int waited;
        compare_count = 0;
        fail_count    = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 48'h0);

        // Reset values while held, then IDLE on the first edge after release.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("post_reset_busy", 64'(bus.busy), 64'd0);

        // Byte-count field: one non-zero byte, all 0xFF, all zero.
        run_message("cnt_one",  48'h01_00_00_00_00_00, 0, 1'b0, 48'h0);
        run_message("cnt_six",  48'hFF_FF_FF_FF_FF_FF, 1, 1'b0, 48'h0);
        run_message("cnt_zero", 48'h00_00_00_00_00_00, 0, 1'b0, 48'h0);

        // Backpressure for five cycles in DONE.
        run_message("backpressure", 48'h12_34_00_78_9A_00, 5, 1'b0, 48'h0);

        for (int i = 0; i < 6; i++) begin
            run_message("random", random_msg(), int'($urandom_range(0, 3)), 1'b0, 48'h0);
        end

        // Abort at round 4, then the same message must produce the fresh-reset digest.
        abort_msg = random_msg();
        applyStimulus(1'b1, abort_msg);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort_accept_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, 48'h0);
        repeat (5) @(negedge clk);
        checkOutput("abort_round_idx", 64'(bus.round_idx), 64'd4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        check_reset_outputs("abort_reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("abort_release_busy", 64'(bus.busy), 64'd0);
        run_message("after_abort", abort_msg, 0, 1'b0, 48'h0);

        // Back-to-back: in_valid never drops; the second message waits for the first digest handshake.
        msg_a = random_msg();
        msg_b = random_msg();
        run_message("b2b_first", msg_a, 2, 1'b1, msg_b);
        run_message("b2b_second", msg_b, 0, 1'b0, 48'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
